archer_projectile_ctrl: RTL and testbench

Slot manager and motion scheduler for the archer's projectiles. It accepts fire requests from the player input logic, allocates a free projectile slot, moves every live projectile once per frame, and retires projectiles on hit, off-screen or expiry. It drives the packed position buses and per-slot enable mask consumed by the archer projectile draw stage, and its hit input comes from the collision logic.

---
 rtl/vga_pkg.sv | 17 +
 rtl/proj_slot_alloc.sv | 23 ++
 rtl/archer_projectile_ctrl.sv | 158 +++++++++++++++
 tb/tb_archer_projectile_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen and projectile definitions for the archer projectile path.
package vga_pkg;

    localparam int         PROJECTILE_COUNT = 4;
    localparam logic [1:0] ARCHER_CLASS     = 2'd2;
    localparam int         X_MIN            = 0;
    localparam int         X_MAX            = 1023;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        dir;
        logic [6:0]  life;
        logic        valid;
    } proj_t;

endpackage

// File: rtl/proj_slot_alloc.sv
// Lowest-index free projectile slot finder.
module proj_slot_alloc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        // Scan downward so the last hit, the lowest free index, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/archer_projectile_ctrl.sv
// Archer projectile slot manager: spawns on fire, moves live slots once per frame,
// retires on hit, screen edge or expiry.
module archer_projectile_ctrl #(
    parameter int PROJECTILE_COUNT = vga_pkg::PROJECTILE_COUNT,
    parameter int PROJ_SPEED       = 4,
    parameter int COOLDOWN_FRAMES  = 15,
    parameter int LIFETIME_FRAMES  = 60,
    parameter int SPAWN_OFS_X      = 16,
    parameter int X_MIN            = vga_pkg::X_MIN,
    parameter int X_MAX            = vga_pkg::X_MAX
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           fire,
    input  logic [11:0]                    char_x,
    input  logic [11:0]                    char_y,
    input  logic                           flip_hor_archer,
    input  logic [1:0]                     game_active,
    input  logic [1:0]                     char_class,
    input  logic                           alive,
    input  logic [PROJECTILE_COUNT-1:0]    hit_mask,
    output logic [PROJECTILE_COUNT*12-1:0] pos_x_proj,
    output logic [PROJECTILE_COUNT*12-1:0] pos_y_proj,
    output logic [PROJECTILE_COUNT-1:0]    projectile_animated,
    output logic                           fire_ack,
    output logic                           fire_drop
);
    import vga_pkg::*;

    localparam int N     = PROJECTILE_COUNT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_UPDATE = 1'b1;

    localparam logic [12:0] XMIN13    = 13'(X_MIN);
    localparam logic [12:0] XMAX13    = 13'(X_MAX);
    localparam logic [12:0] SPEED13   = 13'(PROJ_SPEED);
    localparam logic [12:0] OFS13     = 13'(SPAWN_OFS_X);
    localparam logic [6:0]  LIFE_INIT = 7'(LIFETIME_FRAMES);
    localparam logic [7:0]  CD_INIT   = 8'(COOLDOWN_FRAMES);

    proj_t            slots   [N];
    proj_t            slots_n [N];
    logic [0:0]       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       cooldown, cooldown_n;
    logic             fire_pend, fire_pend_n;
    logic             fire_ack_n, fire_drop_n;
    logic             enable;
    logic [N-1:0]     valid_vec;
    logic [IDX_W-1:0] free_idx;
    logic             any_free;
    logic [12:0]      cur_x;

    function automatic logic [11:0] spawn_pos(input logic [11:0] cx, input logic left);
        logic [12:0] c;
        c = {1'b0, cx};
        if (left)
            return (c < XMIN13 + OFS13) ? XMIN13[11:0] : 12'(c - OFS13);
        else
            return (c + OFS13 > XMAX13) ? XMAX13[11:0] : 12'(c + OFS13);
    endfunction

    assign enable = (game_active != 2'd0) && (char_class == ARCHER_CLASS) && alive;
    assign cur_x  = {1'b0, slots[idx].x};

    for (genvar g = 0; g < N; g++) begin : g_out
        assign pos_x_proj[g*12 +: 12] = slots[g].x;
        assign pos_y_proj[g*12 +: 12] = slots[g].y;
        assign projectile_animated[g] = slots[g].valid;
        assign valid_vec[g]           = slots[g].valid;
    end

    proj_slot_alloc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_alloc (
        .valid    (valid_vec),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_comb begin
        slots_n     = slots;
        state_n     = state;
        idx_n       = idx;
        cooldown_n  = cooldown;
        fire_pend_n = fire_pend | fire;
        fire_ack_n  = 1'b0;
        fire_drop_n = 1'b0;
        case (state)
            S_IDLE: begin
                // frame_tick beats a pending shot; the shot waits for the sweep to finish.
                if (frame_tick) begin
                    state_n = S_UPDATE;
                    idx_n   = '0;
                    if (cooldown != 8'd0) cooldown_n = cooldown - 8'd1;
                end else if (fire_pend_n) begin
                    fire_pend_n = 1'b0;
                    if (cooldown == 8'd0 && any_free) begin
                        slots_n[free_idx].x     = spawn_pos(char_x, flip_hor_archer);
                        slots_n[free_idx].y     = char_y;
                        slots_n[free_idx].dir   = flip_hor_archer;
                        slots_n[free_idx].life  = LIFE_INIT;
                        slots_n[free_idx].valid = 1'b1;
                        cooldown_n = CD_INIT;
                        fire_ack_n = 1'b1;
                    end else begin
                        fire_drop_n = 1'b1;
                    end
                end
            end
            default: begin
                if (slots[idx].valid) begin
                    if (slots[idx].life == 7'd1)
                        slots_n[idx].valid = 1'b0;
                    else if (slots[idx].dir && cur_x < XMIN13 + SPEED13)
                        slots_n[idx].valid = 1'b0;
                    else if (!slots[idx].dir && cur_x + SPEED13 > XMAX13)
                        slots_n[idx].valid = 1'b0;
                    else begin
                        slots_n[idx].x    = slots[idx].dir ? 12'(cur_x - SPEED13)
                                                           : 12'(cur_x + SPEED13);
                        slots_n[idx].life = slots[idx].life - 7'd1;
                    end
                end
                if (idx == IDX_W'(N - 1)) state_n = S_IDLE;
                else                      idx_n   = idx + IDX_W'(1);
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (hit_mask[i]) slots_n[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            for (int i = 0; i < N; i++) slots[i] <= '0;
            state     <= S_IDLE;
            idx       <= '0;
            cooldown  <= '0;
            fire_pend <= 1'b0;
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) slots[i] <= slots_n[i];
            state     <= state_n;
            idx       <= idx_n;
            cooldown  <= cooldown_n;
            fire_pend <= fire_pend_n;
            fire_ack  <= fire_ack_n;
            fire_drop <= fire_drop_n;
        end
    end

endmodule

// File: tb/tb_archer_projectile_ctrl.sv
// Directed bench for archer_projectile_ctrl: default instance plus a no-cooldown, short-life instance.
module tb_archer_projectile_ctrl;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst, frame_tick, fire, flip, alive;
    logic [11:0]     char_x, char_y;
    logic [1:0]      game_active, char_class;
    logic [N-1:0]    hit_mask;
    logic [N*12-1:0] px_a, py_a, px_b, py_b;
    logic [N-1:0]    pa_a, pa_b;
    logic            ack_a, drop_a, ack_b, drop_b;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    archer_projectile_ctrl dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
        .char_x(char_x), .char_y(char_y), .flip_hor_archer(flip),
        .game_active(game_active), .char_class(char_class), .alive(alive),
        .hit_mask(hit_mask), .pos_x_proj(px_a), .pos_y_proj(py_a),
        .projectile_animated(pa_a), .fire_ack(ack_a), .fire_drop(drop_a)
    );

    archer_projectile_ctrl #(.COOLDOWN_FRAMES(0), .LIFETIME_FRAMES(3)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
        .char_x(char_x), .char_y(char_y), .flip_hor_archer(flip),
        .game_active(game_active), .char_class(char_class), .alive(alive),
        .hit_mask(hit_mask), .pos_x_proj(px_b), .pos_y_proj(py_b),
        .projectile_animated(pa_b), .fire_ack(ack_b), .fire_drop(drop_b)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (N) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; fire = 1'b0; flip = 1'b0; alive = 1'b1;
        char_x = 12'd200; char_y = 12'd300; game_active = 2'd1; char_class = 2'd2;
        hit_mask = '0;
        repeat (2) step();
        rst = 1'b0;
        check("reset_mask", pa_a, 0);
        check("reset_x", px_a, 0);
        check("reset_ack", ack_a, 0);
        check("reset_drop", drop_a, 0);

        pulse_fire();
        check("spawn_r_ack", ack_a, 1);
        check("spawn_r_x", px_a[11:0], 216);
        check("spawn_r_y", py_a[11:0], 300);
        check("spawn_r_mask", pa_a, 4'b0001);
        step();
        check("ack_pulse_end", ack_a, 0);

        repeat (3) tick_frame();
        check("move_3_frames", px_a[11:0], 228);

        repeat (2) tick_frame();
        pulse_fire();
        check("cooldown_drop", drop_a, 1);
        check("cooldown_no_ack", ack_a, 0);
        check("cooldown_mask", pa_a, 4'b0001);

        repeat (10) tick_frame();
        check("move_15_frames", px_a[11:0], 276);
        flip = 1'b1;
        pulse_fire();
        check("cooldown_over_ack", ack_a, 1);
        check("spawn_l_mask", pa_a, 4'b0011);
        check("spawn_l_x", px_a[23:12], 184);
        tick_frame();
        check("move_left", px_a[23:12], 180);
        check("move_right_16", px_a[11:0], 280);

        flip = 1'b0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            pulse_fire();
            check($sformatf("fill_ack_%0d", i), ack_b, 1);
        end
        check("full_mask", pa_b, 4'b1111);
        pulse_fire();
        check("full_drop", drop_b, 1);
        check("full_mask_kept", pa_b, 4'b1111);

        hit_mask = 4'b0010;
        step();
        hit_mask = '0;
        check("hit_mask_clear", pa_b, 4'b1101);
        char_x = 12'd400;
        pulse_fire();
        check("reuse_ack", ack_b, 1);
        check("reuse_mask", pa_b, 4'b1111);
        check("reuse_x", px_b[23:12], 416);

        hit_mask = 4'b0001; fire = 1'b1;
        step();
        hit_mask = '0; fire = 1'b0;
        check("hit_same_cycle_drop", drop_b, 1);
        check("hit_same_cycle_mask", pa_b, 4'b1110);
        pulse_fire();
        check("freed_next_ack", ack_b, 1);
        check("freed_next_x", px_b[11:0], 416);

        do_reset();
        char_x = 12'd200;
        pulse_fire();
        check("life_spawn", pa_b, 4'b0001);
        tick_frame();
        check("life_sweep1", pa_b, 4'b0001);
        check("life_sweep1_x", px_b[11:0], 220);
        tick_frame();
        check("life_sweep2", pa_b, 4'b0001);
        tick_frame();
        check("life_sweep3", pa_b, 4'b0000);

        char_x = 12'd1004;
        pulse_fire();
        check("edge_r_x", px_b[11:0], 1020);
        tick_frame();
        check("edge_r_retire", pa_b, 4'b0000);
        char_x = 12'd10; flip = 1'b1;
        pulse_fire();
        check("sat_l_x", px_b[11:0], 0);
        tick_frame();
        check("edge_l_retire", pa_b, 4'b0000);
        char_x = 12'd1020; flip = 1'b0;
        pulse_fire();
        check("sat_r_x", px_b[11:0], 1023);
        tick_frame();
        check("sat_r_retire", pa_b, 4'b0000);

        char_x = 12'd200;
        fire = 1'b1; frame_tick = 1'b1;
        step();
        fire = 1'b0; frame_tick = 1'b0;
        check("tie_no_ack", ack_b, 0);
        repeat (N) step();
        check("tie_sweep_no_ack", ack_b, 0);
        check("tie_sweep_mask", pa_b, 4'b0000);
        step();
        check("tie_after_ack", ack_b, 1);
        check("tie_after_mask", pa_b, 4'b0001);

        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        alive = 1'b0;
        step();
        check("dis_alive_mask", pa_b, 4'b0000);
        check("dis_alive_x", px_b, 0);
        check("dis_alive_y", py_b, 0);
        alive = 1'b1;
        pulse_fire();
        check("dis_alive_idle_ack", ack_b, 1);

        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            if (k == 0) char_class = 2'd1;
            else        game_active = 2'd0;
            step();
            check($sformatf("dis_%0d_mask", k), pa_b, 4'b0000);
            check($sformatf("dis_%0d_x", k), px_b, 0);
            char_class = 2'd2; game_active = 2'd1;
            pulse_fire();
            check($sformatf("dis_%0d_idle_ack", k), ack_b, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
